// File: rtl/sdpb_byte_streamer_if.sv
// sdpb_byte_streamer_if: SDPB port-B read bus plus the outgoing byte stream.
// master = streamer side, slave = RAM/sink side.
interface sdpb_byte_streamer_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
);
    logic              mem_ceb;
    logic              mem_oce;
    logic [ADDR_W-1:0] mem_adb;
    logic [DATA_W-1:0] mem_dout;
    logic [7:0]        m_data;
    logic              m_valid;
    logic              m_ready;
    modport master (output mem_ceb, mem_oce, mem_adb, m_data, m_valid, input mem_dout, m_ready);
    modport slave  (input mem_ceb, mem_oce, mem_adb, m_data, m_valid, output mem_dout, m_ready);
endinterface

// File: rtl/sdpb_byte_streamer.sv
// sdpb_byte_streamer: reads a wrapping run of 16-bit words from SDPB port B and
// emits each one as two bytes on a valid/ready stream, one word in flight at a time.
module sdpb_byte_streamer #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1,
    parameter bit MSB_FIRST  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [7:0]          len,
    output logic                busy,
    output logic                done,
    sdpb_byte_streamer_if.master bus
);
    localparam int DEPTH = 1 << ADDR_W;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, BYTE0, BYTE1, FIN} state_t;
    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   rem_q;
    logic [ADDR_W:0]   len_sat;
    logic [1:0]        wcnt_q;
    logic [DATA_W-1:0] word_q;
    logic              last_wait;
    logic              hs;
    logic              accept;
    assign len_sat   = (int'(len) > DEPTH) ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(len);
    assign last_wait = wcnt_q == 2'(RD_LATENCY - 1);
    assign hs        = bus.m_valid && bus.m_ready;
    assign accept    = state == IDLE && start && len != 8'd0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr_q <= '0;
            rem_q  <= '0;
            wcnt_q <= '0;
            word_q <= '0;
        end else begin
            state  <= state_nx;
            wcnt_q <= state == WAIT ? wcnt_q + 2'd1 : 2'd0;
            if (accept) begin
                addr_q <= start_addr;
                rem_q  <= len_sat;
            end
            if (state == BYTE1 && hs) begin
                addr_q <= addr_q + 1'b1;
                rem_q  <= rem_q - 1'b1;
            end
            if (state == WAIT && last_wait) word_q <= bus.mem_dout;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = len == 8'd0 ? FIN : ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (last_wait) state_nx = BYTE0;
            BYTE0:   if (hs) state_nx = BYTE1;
            BYTE1:   if (hs) state_nx = rem_q == (ADDR_W+1)'(1) ? FIN : ISSUE;
            default: state_nx = IDLE;
        endcase
        // abort overrides everything once a transfer is running; IDLE ignores it so start wins
        if (busy && abort) state_nx = FIN;
    end
    assign busy        = state == ISSUE || state == WAIT || state == BYTE0 || state == BYTE1;
    assign done        = state == FIN;
    assign bus.mem_ceb = state == ISSUE;
    assign bus.mem_oce = RD_LATENCY == 2 && state == WAIT && last_wait;
    assign bus.mem_adb = addr_q;
    assign bus.m_valid = state == BYTE0 || state == BYTE1;
    assign bus.m_data  = state == BYTE0 ? (MSB_FIRST ? word_q[15:8] : word_q[7:0]) :
                         state == BYTE1 ? (MSB_FIRST ? word_q[7:0] : word_q[15:8]) : 8'd0;
endmodule

// File: tb/tb_sdpb_byte_streamer.sv
// tb_sdpb_byte_streamer: four streamers (RD_LATENCY 1/2 x MSB_FIRST 1/0) against a
// behavioural port-B RAM holding 16'hA500+addr; expected bytes go through a scoreboard queue.
module tb_sdpb_byte_streamer;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic        abort = 0;
    logic [6:0]  start_addr = '0;
    logic [7:0]  len = '0;
    logic        m_ready;
    logic        rand_rdy = 0;
    logic        rdy_fix = 1;
    logic        rnd_bit = 0;
    int          sel = 0;
    logic [3:0]  busy_a, done_a, m_valid_a, mem_ceb_a, mem_oce_a;
    logic [7:0]  m_data_a [4];
    logic [19:0] outs_a [4];
    logic [7:0]  q [$];
    int          n_checks = 0, n_errors = 0;
    int          nbytes = 0, ceb_cnt = 0, oce_cnt = 0, done_cnt = 0;
    logic        stall_q = 0;
    logic [7:0]  held_q = '0;
    always #5 clk = ~clk;
    assign m_ready = rand_rdy ? rnd_bit : rdy_fix;
    always begin
        @(posedge clk);
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end
    sdpb_byte_streamer_if bus [4] ();
    for (genvar g = 0; g < 4; g++) begin : u
        localparam int LAT = g >= 2 ? 2 : 1;
        localparam bit MSB = (g % 2) == 0;
        logic [15:0] r1, d2;
        sdpb_byte_streamer #(.RD_LATENCY(LAT), .MSB_FIRST(MSB)) dut (
            .clk(clk), .rst_n(rst_n), .start(start && sel == g), .abort(abort && sel == g),
            .start_addr(start_addr), .len(len), .busy(busy_a[g]), .done(done_a[g]), .bus(bus[g]));
        always @(posedge clk) begin
            if (bus[g].mem_ceb) r1 <= 16'hA500 + 16'(bus[g].mem_adb);
            d2 <= r1;
        end
        assign bus[g].mem_dout = LAT == 2 ? d2 : r1;
        assign bus[g].m_ready  = m_ready;
        assign m_valid_a[g]    = bus[g].m_valid;
        assign mem_ceb_a[g]    = bus[g].mem_ceb;
        assign mem_oce_a[g]    = bus[g].mem_oce;
        assign m_data_a[g]     = bus[g].m_data;
        assign outs_a[g]       = {busy_a[g], done_a[g], bus[g].m_valid, bus[g].mem_ceb,
                                  bus[g].mem_oce, bus[g].mem_adb, bus[g].m_data};
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (inst %0d, t=%0t): got %0h expected %0h", tag, sel, $time, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid_a[sel] && m_ready) begin
                nbytes++;
                if (q.size() != 0) check("byte", 32'(m_data_a[sel]), 32'(q.pop_front()));
                else check("extra_byte", 32'(m_data_a[sel]), 32'h1FF);
            end
            if (stall_q && m_valid_a[sel]) check("hold", 32'(m_data_a[sel]), 32'(held_q));
            stall_q = m_valid_a[sel] && !m_ready;
            held_q  = m_data_a[sel];
            if (mem_ceb_a[sel]) begin
                ceb_cnt++;
                check("ceb_busy", 32'(busy_a[sel]), 1);
            end
            oce_cnt  += int'(mem_oce_a[sel]);
            done_cnt += int'(done_a[sel]);
        end else stall_q = 0;
    end
    function automatic bit msb_sel();
        return (sel % 2) == 0;
    endfunction
    function automatic bit lat2_sel();
        return sel >= 2;
    endfunction
    task automatic push_words(input int a, input int n);
        for (int k = 0; k < n; k++) begin
            logic [7:0] lo;
            lo = 8'((a + k) % 128);
            if (msb_sel()) begin
                q.push_back(8'hA5);
                q.push_back(lo);
            end else begin
                q.push_back(lo);
                q.push_back(8'hA5);
            end
        end
    endtask
    task automatic pulse_start(input int a, input int l);
        @(posedge clk);
        #1 start = 1; start_addr = 7'(a); len = 8'(l);
        @(posedge clk);
        #1 start = 0;
    endtask
    task automatic sample();
        @(negedge clk);
        #1;
    endtask
    task automatic wait_done();
        int t = 0;
        while (!done_a[sel] && t < 3000) begin
            sample();
            t++;
        end
        check("done_seen", 32'(done_a[sel]), 1);
        check("busy_at_done", 32'(busy_a[sel]), 0);
    endtask
    task automatic xfer(input int a, input int l, input bit rnd, input bit dup);
        int words = l > 128 ? 128 : l;
        int c0 = ceb_cnt, o0 = oce_cnt, d0 = done_cnt;
        rand_rdy = rnd;
        push_words(a, words);
        pulse_start(a, l);
        sample();
        check("busy_after_start", 32'(busy_a[sel]), 32'(words != 0));
        if (dup) pulse_start(90, 3);
        wait_done();
        repeat (3) sample();
        check("queue_left", q.size(), 0);
        check("ceb_count", ceb_cnt - c0, words);
        check("oce_count", oce_cnt - o0, lat2_sel() ? words : 0);
        check("done_count", done_cnt - d0, 1);
        rand_rdy = 0;
    endtask
    task automatic abort_test();
        int c0 = ceb_cnt, d0 = done_cnt, b0 = nbytes, t = 0;
        push_words(40, 2);
        void'(q.pop_back());
        pulse_start(40, 10);
        while (nbytes - b0 < 3 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("abort_reach3", nbytes - b0, 3);
        #1 abort = 1; rdy_fix = 0;
        @(posedge clk);
        #1 abort = 0;
        sample();
        check("abort_valid", 32'(m_valid_a[sel]), 0);
        check("abort_done", 32'(done_a[sel]), 1);
        check("abort_busy", 32'(busy_a[sel]), 0);
        repeat (5) sample();
        check("abort_ceb", ceb_cnt - c0, 2);
        check("abort_done_n", done_cnt - d0, 1);
        check("abort_queue", q.size(), 0);
        rdy_fix = 1;
    endtask
    task automatic reset_test();
        int d0 = done_cnt;
        push_words(50, 5);
        pulse_start(50, 5);
        repeat (7) @(posedge clk);
        #1 rst_n = 0;
        sample();
        check("midrst_outs", 32'(outs_a[sel]), 0);
        @(posedge clk);
        #1 rst_n = 1;
        q.delete();
        repeat (4) sample();
        check("midrst_nodone", done_cnt - d0, 0);
        check("midrst_idle", 32'(outs_a[sel]), 0);
        xfer(0, 2, 0, 0);
    endtask
    initial begin
        repeat (3) @(posedge clk);
        sample();
        for (int s = 0; s < 4; s++) begin
            sel = s;
            check("reset_outs", 32'(outs_a[s]), 0);
        end
        @(posedge clk);
        #1 rst_n = 1;
        for (int s = 0; s < 4; s++) begin
            sel = s;
            xfer(0, 2, 0, 0);
            xfer(126, 4, 0, 0);
            xfer(5, 20, 1, 0);
            abort_test();
            xfer(0, 0, 0, 0);
            xfer(120, 200, 0, 0);
            xfer(120, 16, 1, 0);
            xfer(10, 6, 0, 1);
            reset_test();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
